// File: rtl/frequency_divider.sv
// Programmable 50%-duty clock divider: clk_out = f(clk) / (mc + 1).
// Even ratios use the rising-edge counter only. Odd ratios OR a rising-edge
// and a falling-edge term so that the high phase ends on a half period.
module frequency_divider #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] mc,
  output logic [WIDTH-1:0] pos_count,
  output logic [WIDTH-1:0] neg_count,
  output logic             clk_out
);

  typedef enum logic [1:0] {
    MODE_OFF,   // mc == 0: ratio of 1 is not supported, output parked low
    MODE_EVEN,  // mc odd: even ratio, rising-edge counter alone sets the duty
    MODE_ODD    // mc even and >= 2: odd ratio, both counters contribute
  } mode_e;

  logic [WIDTH-1:0] pos_count_q, pos_count_d;
  logic [WIDTH-1:0] neg_count_q, neg_count_d;
  logic [WIDTH-1:0] half;
  mode_e            mode;
  logic             clk_div;

  // Next counts: >= rather than == so a lowered mc wraps on the next edge
  always_comb begin
    pos_count_d = (pos_count_q >= mc) ? '0 : pos_count_q + 1'b1;
    neg_count_d = (neg_count_q >= mc) ? '0 : neg_count_q + 1'b1;
  end

  // Rising-edge counter with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) pos_count_q <= '0;
    else       pos_count_q <= pos_count_d;
  end

  // Falling-edge counter; reset is sampled on the falling edge as well, so
  // after release it trails the rising-edge counter by half an input period
  always_ff @(negedge clk) begin
    if (reset) neg_count_q <= '0;
    else       neg_count_q <= neg_count_d;
  end

  // Decode division mode from the terminal count
  always_comb begin
    half = mc >> 1;
    mode = MODE_OFF;
    if (mc == '0)    mode = MODE_OFF;
    else if (mc[0])  mode = MODE_EVEN;
    else             mode = MODE_ODD;
  end

  // Divided clock from registered counts. In odd mode the two terms overlap
  // around every transition, so the OR is glitch-free for a static mc.
  always_comb begin
    clk_div = 1'b0;
    unique case (mode)
      MODE_EVEN: clk_div = (pos_count_q <= half);
      MODE_ODD:  clk_div = (pos_count_q < half) || (neg_count_q < half);
      default:   clk_div = 1'b0;
    endcase
  end

  assign clk_out   = reset ? 1'b0 : clk_div;
  assign pos_count = pos_count_q;
  assign neg_count = neg_count_q;

endmodule

// File: tb/tb_frequency_divider.sv
// Directed bench for frequency_divider: counter sequences, output level per
// half period, duty/period measurement, mid-run reset and mc change.
module tb_frequency_divider;

  localparam int unsigned WIDTH = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic [WIDTH-1:0] mc;
  logic [WIDTH-1:0] pos_count;
  logic [WIDTH-1:0] neg_count;
  logic             clk_out;

  int tests_run = 0;
  int tests_failed = 0;

  frequency_divider #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .mc        (mc),
    .pos_count (pos_count),
    .neg_count (neg_count),
    .clk_out   (clk_out)
  );

  // 10 ns input clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Hold reset across two full clocks with the given mc, check reset state,
  // then release just after a falling edge.
  task automatic do_reset(input logic [WIDTH-1:0] mc_val);
    mc    = mc_val;
    reset = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk); #1;
    check("rst_pos", 32'(pos_count), 0);
    check("rst_neg", 32'(neg_count), 0);
    check("rst_out", 32'(clk_out), 0);
    reset = 1'b0;
  endtask

  // Check n cycles after a release-at-falling-edge. pos_mask[p]/neg_mask[p]
  // give the expected clk_out just after the rising/falling edge on which
  // pos_count becomes p.
  task automatic check_seq(input string tag, input int n_ratio, input int cycles,
                           input logic [15:0] pos_mask, input logic [15:0] neg_mask);
    int p;
    for (int k = 1; k <= cycles; k++) begin
      p = k % n_ratio;
      @(posedge clk); #1;
      check({tag, "_pos"},   32'(pos_count), 32'(p));
      check({tag, "_negtr"}, 32'(neg_count), 32'((k - 1) % n_ratio));
      check({tag, "_outp"},  32'(clk_out),   32'(pos_mask[p]));
      @(negedge clk); #1;
      check({tag, "_neg"},   32'(neg_count), 32'(p));
      check({tag, "_outn"},  32'(clk_out),   32'(neg_mask[p]));
    end
  endtask

  // Skip one full output period, then measure the next high and low phase in
  // ns by sampling just after every input edge (5 ns per sample).
  task automatic measure(input string tag, input int exp_hi_ns, input int exp_lo_ns);
    int   budget = 400;
    int   rises  = 0;
    int   hi     = 0;
    int   lo     = 0;
    logic prev;
    prev = clk_out;
    while (rises < 2 && budget > 0) begin
      @(clk); #1;
      budget--;
      if (!prev && clk_out) rises++;
      prev = clk_out;
    end
    if (rises == 2) begin
      hi = 1;
      while (budget > 0) begin
        @(clk); #1;
        budget--;
        if (clk_out) hi++;
        else break;
      end
      lo = 1;
      while (budget > 0) begin
        @(clk); #1;
        budget--;
        if (!clk_out) lo++;
        else break;
      end
    end
    check({tag, "_high_ns"}, 32'(hi * 5), 32'(exp_hi_ns));
    check({tag, "_low_ns"},  32'(lo * 5), 32'(exp_lo_ns));
  endtask

  initial begin
    reset = 1'b1;
    mc    = 4'd6;

    // N=7: high when pos<3 or neg<3 -> 35/35 ns
    do_reset(4'd6);
    check_seq("n7", 7, 15, 16'h000F, 16'h0007);
    measure("n7", 35, 35);

    // N=4: high while pos_count is 0 or 1 -> 20/20 ns
    do_reset(4'd3);
    check_seq("n4", 4, 9, 16'h0003, 16'h0003);
    measure("n4", 20, 20);

    // N=3: rises on the rising edge where pos_count becomes 0 -> 15/15 ns
    do_reset(4'd2);
    check_seq("n3", 3, 7, 16'h0003, 16'h0001);
    measure("n3", 15, 15);

    // N=2: toggles every rising edge -> 10/10 ns
    do_reset(4'd1);
    check_seq("n2", 2, 5, 16'h0001, 16'h0001);
    measure("n2", 10, 10);

    // N=16: full-width count to 15 -> 80/80 ns
    do_reset(4'd15);
    check_seq("n16", 16, 18, 16'h00FF, 16'h00FF);
    measure("n16", 80, 80);

    // mc=0: counters stay at 0, output stays low
    do_reset(4'd0);
    check_seq("n1", 1, 6, 16'h0000, 16'h0000);

    // Mid-run reset with N=7, asserted while clk_out is high (pos=neg=2)
    do_reset(4'd6);
    check_seq("pre_rst", 7, 9, 16'h000F, 16'h0007);
    reset = 1'b1;
    #1;
    check("midrst_out_now", 32'(clk_out), 0);
    @(posedge clk); #1;
    check("midrst_pos0", 32'(pos_count), 0);
    check("midrst_neg_hold", 32'(neg_count), 2);
    check("midrst_out_p", 32'(clk_out), 0);
    @(negedge clk); #1;
    check("midrst_neg0", 32'(neg_count), 0);
    check("midrst_out_n", 32'(clk_out), 0);
    reset = 1'b0;
    check_seq("post_rst", 7, 9, 16'h000F, 16'h0007);

    // Lower mc from 6 to 2 while pos_count=5: immediate wrap, then N=3
    do_reset(4'd6);
    check_seq("pre_mc", 7, 5, 16'h000F, 16'h0007);
    mc = 4'd2;
    @(posedge clk); #1;
    check("mcchg_pos_wrap", 32'(pos_count), 0);
    check("mcchg_neg_old", 32'(neg_count), 5);
    check("mcchg_out", 32'(clk_out), 1);
    @(negedge clk); #1;
    check("mcchg_neg_wrap", 32'(neg_count), 0);
    measure("mcchg_n3", 15, 15);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Absolute time limit so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout: simulation still running at %0t, limit 200000", $time);
    $fatal(1, "timeout");
  end

endmodule
